// File: rtl/pll_lock_supervisor.sv
// Board-clock-side rPLL supervisor: pulses PLL reset, qualifies a stable lock,
// holds the system in reset for a while, then releases it; relocks on lock loss or timeout.
module pll_lock_supervisor #(
   parameter int RST_CYCLES     = 16,
   parameter int STABLE_CYCLES  = 1024,
   parameter int HOLD_CYCLES    = 64,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       i_clk,
   input  logic       i_resetn,
   input  logic       i_pll_lock,
   input  logic       i_relock_req,
   input  logic       i_clr_status,
   output logic       o_pll_reset,
   output logic       o_sys_resetn,
   output logic       o_locked,
   output logic [1:0] o_state,
   output logic [7:0] o_loss_count,
   output logic [7:0] o_retry_count,
   output logic       o_timeout_flag
);

   localparam int M0 = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
   localparam int M1 = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
   localparam int MX = (M0 > M1) ? M0 : M1;
   localparam int CW = $clog2(MX + 1);

   localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_PLL_RST   = 2'd0,
      S_WAIT_LOCK = 2'd1,
      S_HOLD      = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   state_t                 r_state, w_next;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt, w_cnt_next;
   logic [CW-1:0]          r_stab, w_stab_next;
   logic                   r_pll_reset, r_sys_resetn, r_locked;
   logic [7:0]             r_loss, r_retry;
   logic                   r_tflag;
   logic                   w_lock_s, w_loss_ev, w_to_ev;

   assign w_lock_s = r_sync[SYNC_STAGES-1];

   always_comb begin
      w_next    = r_state;
      w_loss_ev = 1'b0;
      w_to_ev   = 1'b0;
      case (r_state)
         S_PLL_RST: begin
            if (r_cnt == RST_LAST) w_next = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            // qualification is checked before the timeout so it wins a tie
            if (i_relock_req)                     w_next = S_PLL_RST;
            else if (w_lock_s && r_stab == STAB_LAST) w_next = S_HOLD;
            else if (r_cnt == TO_LAST) begin
               w_next  = S_PLL_RST;
               w_to_ev = 1'b1;
            end
         end
         S_HOLD: begin
            if (i_relock_req)            w_next = S_PLL_RST;
            else if (!w_lock_s)          w_next = S_WAIT_LOCK;
            else if (r_cnt == HOLD_LAST) w_next = S_RUN;
         end
         default: begin
            if (!w_lock_s) begin
               w_next    = S_PLL_RST;
               w_loss_ev = 1'b1;
            end else if (i_relock_req) begin
               w_next = S_PLL_RST;
            end
         end
      endcase
      // every transition is a state change, so this also clears cnt on entry
      w_cnt_next  = (w_next != r_state) ? '0 : r_cnt + CW'(1);
      w_stab_next = '0;
      if (r_state == S_WAIT_LOCK && w_next == S_WAIT_LOCK && w_lock_s)
         w_stab_next = r_stab + CW'(1);
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state      <= S_PLL_RST;
         r_sync       <= '0;
         r_cnt        <= '0;
         r_stab       <= '0;
         r_pll_reset  <= 1'b1;
         r_sys_resetn <= 1'b0;
         r_locked     <= 1'b0;
         r_loss       <= '0;
         r_retry      <= '0;
         r_tflag      <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_sync       <= {r_sync[SYNC_STAGES-2:0], i_pll_lock};
         r_cnt        <= w_cnt_next;
         r_stab       <= w_stab_next;
         r_pll_reset  <= (w_next == S_PLL_RST);
         r_sys_resetn <= (w_next == S_RUN);
         r_locked     <= (w_next == S_RUN);
         if (i_clr_status) begin
            r_loss  <= '0;
            r_retry <= '0;
            r_tflag <= 1'b0;
         end else begin
            if (w_loss_ev && r_loss != 8'hFF)  r_loss  <= r_loss + 8'd1;
            if (w_to_ev && r_retry != 8'hFF)   r_retry <= r_retry + 8'd1;
            if (w_to_ev)                       r_tflag <= 1'b1;
         end
      end
   end

   assign o_pll_reset    = r_pll_reset;
   assign o_sys_resetn   = r_sys_resetn;
   assign o_locked       = r_locked;
   assign o_state        = r_state;
   assign o_loss_count   = r_loss;
   assign o_retry_count  = r_retry;
   assign o_timeout_flag = r_tflag;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short phase lengths
// (RST=4, STABLE=8, HOLD=4, TIMEOUT=32, SYNC=2); checks by immediate assertions.
module tb_pll_lock_supervisor;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       pll_lock = 1'b0;
   logic       relock_req = 1'b0;
   logic       clr_status = 1'b0;
   logic       pll_reset, sys_resetn, locked, timeout_flag;
   logic [1:0] state;
   logic [7:0] loss_count, retry_count;

   int n_vec  = 0;
   int n_miss = 0;
   bit pat [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   always #5 clk = ~clk;

   pll_lock_supervisor #(
      .RST_CYCLES(4), .STABLE_CYCLES(8), .HOLD_CYCLES(4),
      .TIMEOUT_CYCLES(32), .SYNC_STAGES(2)
   ) dut (
      .i_clk(clk), .i_resetn(resetn), .i_pll_lock(pll_lock),
      .i_relock_req(relock_req), .i_clr_status(clr_status),
      .o_pll_reset(pll_reset), .o_sys_resetn(sys_resetn), .o_locked(locked),
      .o_state(state), .o_loss_count(loss_count), .o_retry_count(retry_count),
      .o_timeout_flag(timeout_flag)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp)
      else begin
         n_miss++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reset for two edges; release lands 1 time unit after an edge, so tick(k) = k edges after release.
   task automatic do_reset();
      resetn = 1'b0;
      tick(2);
      resetn = 1'b1;
   endtask

   initial begin
      // 1: power-up sequence with lock already high
      pll_lock = 1'b1;
      resetn = 1'b0;
      tick(2);
      chk("rst_state", 32'(state), 0);
      chk("rst_pll_reset", 32'(pll_reset), 1);
      chk("rst_sys_resetn", 32'(sys_resetn), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_loss", 32'(loss_count), 0);
      chk("rst_retry", 32'(retry_count), 0);
      chk("rst_tflag", 32'(timeout_flag), 0);
      resetn = 1'b1;
      tick(3);
      chk("t1_pllrst_c3", 32'(pll_reset), 1);
      tick(1);
      chk("t1_pllrst_c4", 32'(pll_reset), 0);
      chk("t1_wait_state", 32'(state), 1);
      tick(8);
      chk("t1_hold_state", 32'(state), 2);
      tick(3);
      chk("t1_sysn_c15", 32'(sys_resetn), 0);
      tick(1);
      chk("t1_sysn_c16", 32'(sys_resetn), 1);
      chk("t1_run_state", 32'(state), 3);
      chk("t1_locked", 32'(locked), 1);

      // 2: one-cycle lock drop in RUN
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      tick(1);
      chk("t2_sysn_still_hi", 32'(sys_resetn), 1);
      tick(1);
      chk("t2_sysn_lo", 32'(sys_resetn), 0);
      chk("t2_state", 32'(state), 0);
      chk("t2_loss", 32'(loss_count), 1);
      chk("t2_locked", 32'(locked), 0);
      chk("t2_pll_reset", 32'(pll_reset), 1);
      tick(3);
      chk("t2_pllrst_c4", 32'(pll_reset), 1);
      tick(1);
      chk("t2_pllrst_end", 32'(pll_reset), 0);
      tick(11);
      chk("t2_sysn_before", 32'(sys_resetn), 0);
      tick(1);
      chk("t2_sysn_back", 32'(sys_resetn), 1);

      // 5b: clr_status coinciding with a second loss
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      tick(1);
      clr_status = 1'b1;
      tick(1);
      clr_status = 1'b0;
      chk("t5_clr_loss_state", 32'(state), 0);
      chk("t5_clr_loss_cnt", 32'(loss_count), 0);

      // 5: relock_req during PLL_RST is ignored
      relock_req = 1'b1;
      tick(1);
      relock_req = 1'b0;
      tick(2);
      chk("t5_pllrst_c4", 32'(pll_reset), 1);
      tick(1);
      chk("t5_pllrst_end", 32'(pll_reset), 0);
      chk("t5_wait", 32'(state), 1);
      tick(12);
      chk("t5_run", 32'(state), 3);
      // relock_req in RUN: restart without counting a loss
      relock_req = 1'b1;
      tick(1);
      relock_req = 1'b0;
      chk("t5_relock_state", 32'(state), 0);
      chk("t5_relock_loss", 32'(loss_count), 0);
      chk("t5_relock_sysn", 32'(sys_resetn), 0);

      // 4: lock drop in HOLD goes back to WAIT_LOCK, not a loss
      pll_lock = 1'b1;
      do_reset();
      tick(12);
      chk("t4_hold", 32'(state), 2);
      pll_lock = 1'b0;
      tick(2);
      chk("t4_hold_sync", 32'(state), 2);
      tick(1);
      chk("t4_hold_drop", 32'(state), 1);
      chk("t4_hold_loss", 32'(loss_count), 0);
      chk("t4_hold_sysn", 32'(sys_resetn), 0);

      // 4: flickering lock never qualifies; times out after 32 WAIT cycles
      resetn = 1'b0;
      tick(2);
      resetn = 1'b1;
      pll_lock = pat[0];
      for (int i = 1; i <= 36; i++) begin
         tick(1);
         pll_lock = pat[i % 6];
         if (i >= 4 && i <= 35) chk("t4_flicker_wait", 32'(state), 1);
      end
      chk("t4_flicker_to", 32'(state), 0);
      chk("t4_flicker_retry", 32'(retry_count), 1);
      chk("t4_flicker_tflag", 32'(timeout_flag), 1);

      // 3: lock held low, repeated timeouts, retry_count saturates
      pll_lock = 1'b0;
      do_reset();
      tick(35);
      chk("t3_wait_c35", 32'(state), 1);
      chk("t3_retry0", 32'(retry_count), 0);
      tick(1);
      chk("t3_to_state", 32'(state), 0);
      chk("t3_to_pllrst", 32'(pll_reset), 1);
      chk("t3_retry1", 32'(retry_count), 1);
      chk("t3_tflag", 32'(timeout_flag), 1);
      tick(36);
      chk("t3_retry2", 32'(retry_count), 2);
      tick(298 * 36);
      chk("t3_retry_sat", 32'(retry_count), 255);

      // 6: async reset with counters set, then mid-HOLD and mid-RUN
      resetn = 1'b0;
      #1;
      chk("t6_ctr_retry", 32'(retry_count), 0);
      chk("t6_ctr_tflag", 32'(timeout_flag), 0);
      tick(1);
      pll_lock = 1'b1;
      resetn = 1'b1;
      tick(13);
      chk("t6_in_hold", 32'(state), 2);
      resetn = 1'b0;
      #1;
      chk("t6_hold_state", 32'(state), 0);
      chk("t6_hold_pllrst", 32'(pll_reset), 1);
      chk("t6_hold_sysn", 32'(sys_resetn), 0);
      tick(1);
      resetn = 1'b1;
      tick(18);
      chk("t6_in_run", 32'(state), 3);
      resetn = 1'b0;
      #1;
      chk("t6_run_state", 32'(state), 0);
      chk("t6_run_sysn", 32'(sys_resetn), 0);
      chk("t6_run_locked", 32'(locked), 0);
      chk("t6_run_pllrst", 32'(pll_reset), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
